rv32i_mc_controller: RTL and testbench

- Next-generation multicycle RV32I control FSM. It drives the IR, PC, register-file, ALU-operand and memory-port controls of the shared datapath.
- Adds over the prior controller:
  - a req/ready memory handshake with wait states;
  - a per-access timeout;
  - conditional branches, LUI and AUIPC;
  - precise traps for illegal opcodes and bus timeouts, with a configurable halt.
- Sits between the IR opcode field and the datapath muxes. It never touches data; data stays in the datapath.

---
 rtl/rv32i_mc_controller.sv | 191 +++++++++++++++++++
 tb/tb_rv32i_mc_controller.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mc_controller.sv
// rtl/rv32i_mc_controller.sv - multicycle RV32I control FSM with mem handshake, timeout and traps
module rv32i_mc_controller #(
   parameter int WIDTH        = 32,
   parameter int MEM_TIMEOUT  = 16,
   parameter int HALT_ON_TRAP = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       branch_taken,
   input  logic       mem_ready,
   output logic       ir_wren,
   output logic       pc_wren,
   output logic [1:0] pc_sel,
   output logic       regfile_wren,
   output logic [1:0] regfile_sel,
   output logic       alu_a_sel,
   output logic       alu_b_sel,
   output logic       mem_req,
   output logic       mem_we,
   output logic       mem_addr_sel,
   output logic       instret,
   output logic       trap,
   output logic [3:0] trap_cause,
   output logic       halted
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   // A zero timeout still needs a 1-bit counter so the declaration stays legal.
   localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LIMIT = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   generate
      if (WIDTH != 32) begin : g_width_check
         $error("rv32i_mc_controller: WIDTH must be 32");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP, S_HALT
   } state_t;

   state_t        state, state_next;
   logic [CW-1:0] wait_cnt;
   logic [3:0]    cause_next;
   logic          timeout_hit;
   logic          opcode_legal;

   assign timeout_hit  = (MEM_TIMEOUT > 0) && (wait_cnt == CNT_LIMIT) && !mem_ready;
   assign opcode_legal = (opcode == OPC_OP)     || (opcode == OPC_OP_IMM) ||
                         (opcode == OPC_LUI)    || (opcode == OPC_AUIPC)  ||
                         (opcode == OPC_BRANCH) || (opcode == OPC_JAL)    ||
                         (opcode == OPC_JALR)   || (opcode == OPC_LOAD)   ||
                         (opcode == OPC_STORE);

   // State register and trap cause, which latches only on the edge into TRAP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_FETCH;
         trap_cause <= 4'd0;
      end else begin
         state <= state_next;
         if (state_next == S_TRAP)
            trap_cause <= cause_next;
      end
   end

   // Wait-state counter: runs only while an access is stalled, cleared on any state change or ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wait_cnt <= '0;
      else if ((state_next == state) && ((state == S_FETCH) || (state == S_MEM)) && !mem_ready)
         wait_cnt <= wait_cnt + CW'(1);
      else
         wait_cnt <= '0;
   end

   // Next-state and control decode; everything is forced low while rst is held.
   always_comb begin
      state_next   = state;
      cause_next   = trap_cause;
      ir_wren      = 1'b0;
      pc_wren      = 1'b0;
      pc_sel       = 2'd0;
      regfile_wren = 1'b0;
      regfile_sel  = 2'd0;
      alu_a_sel    = 1'b0;
      alu_b_sel    = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      instret      = 1'b0;
      trap         = 1'b0;
      halted       = 1'b0;
      if (!rst) begin
         case (state)
            S_FETCH: begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  ir_wren    = 1'b1;
                  pc_wren    = 1'b1;
                  state_next = S_DECODE;
               end else if (timeout_hit) begin
                  cause_next = 4'd1;
                  state_next = S_TRAP;
               end
            end
            S_DECODE: begin
               if (opcode_legal) begin
                  state_next = S_EXEC;
               end else begin
                  cause_next = 4'd2;
                  state_next = S_TRAP;
               end
            end
            S_EXEC: begin
               state_next = S_FETCH;
               case (opcode)
                  OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
                     alu_a_sel    = (opcode == OPC_AUIPC);
                     alu_b_sel    = (opcode != OPC_OP);
                     regfile_wren = 1'b1;
                     instret      = 1'b1;
                  end
                  OPC_BRANCH: begin
                     pc_wren = branch_taken;
                     pc_sel  = branch_taken ? 2'd2 : 2'd0;
                     instret = 1'b1;
                  end
                  OPC_JAL: begin
                     regfile_wren = 1'b1;
                     regfile_sel  = 2'd2;
                     pc_wren      = 1'b1;
                     pc_sel       = 2'd2;
                     instret      = 1'b1;
                  end
                  OPC_JALR: begin
                     alu_b_sel    = 1'b1;
                     regfile_wren = 1'b1;
                     regfile_sel  = 2'd2;
                     pc_wren      = 1'b1;
                     pc_sel       = 2'd1;
                     instret      = 1'b1;
                  end
                  OPC_LOAD, OPC_STORE: begin
                     alu_b_sel  = 1'b1;
                     state_next = S_MEM;
                  end
                  default: state_next = S_FETCH;
               endcase
            end
            S_MEM: begin
               mem_req      = 1'b1;
               mem_addr_sel = 1'b1;
               mem_we       = (opcode == OPC_STORE);
               if (mem_ready) begin
                  instret    = (opcode == OPC_STORE);
                  state_next = (opcode == OPC_STORE) ? S_FETCH : S_WB;
               end else if (timeout_hit) begin
                  cause_next = (opcode == OPC_STORE) ? 4'd7 : 4'd5;
                  state_next = S_TRAP;
               end
            end
            S_WB: begin
               regfile_wren = 1'b1;
               regfile_sel  = 2'd1;
               instret      = 1'b1;
               state_next   = S_FETCH;
            end
            S_TRAP: begin
               trap       = 1'b1;
               pc_wren    = 1'b1;
               pc_sel     = 2'd3;
               state_next = (HALT_ON_TRAP != 0) ? S_HALT : S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: state_next = S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32i_mc_controller.sv
// tb/tb_rv32i_mc_controller.sv - randomized transaction-level check of rv32i_mc_controller
module tb_rv32i_mc_controller;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   typedef struct packed {
      logic       ir_wren;
      logic       pc_wren;
      logic [1:0] pc_sel;
      logic       regfile_wren;
      logic [1:0] regfile_sel;
      logic       alu_a_sel;
      logic       alu_b_sel;
      logic       mem_req;
      logic       mem_we;
      logic       mem_addr_sel;
      logic       instret;
      logic       trap;
      logic       halted;
      logic [3:0] trap_cause;
   } outs_t;

   typedef struct {
      logic [6:0] opcode;
      logic       branch_taken;
      logic       mem_ready;
      outs_t      exp;
      string      tag;
   } step_t;

   logic       clk = 1'b0;
   logic       rst_a, rst_b;
   logic [6:0] opcode;
   logic       branch_taken, mem_ready;

   logic       a_ir, a_pcw, a_rfw, a_as, a_bs, a_req, a_we, a_ms, a_ret, a_trap, a_halt;
   logic [1:0] a_pcs, a_rfs;
   logic [3:0] a_cause;
   logic       b_ir, b_pcw, b_rfw, b_as, b_bs, b_req, b_we, b_ms, b_ret, b_trap, b_halt;
   logic [1:0] b_pcs, b_rfs;
   logic [3:0] b_cause;
   outs_t      out_a, out_b;

   int         checks = 0;
   int         failures = 0;
   logic [3:0] cause_exp = 4'd0;
   bit         sel_b = 1'b0;
   step_t      plan[$];
   logic [6:0] legal_ops[9] = '{OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_BRANCH,
                               OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE};

   always #5 clk = ~clk;

   assign out_a = {a_ir, a_pcw, a_pcs, a_rfw, a_rfs, a_as, a_bs, a_req, a_we, a_ms, a_ret, a_trap, a_halt, a_cause};
   assign out_b = {b_ir, b_pcw, b_pcs, b_rfw, b_rfs, b_as, b_bs, b_req, b_we, b_ms, b_ret, b_trap, b_halt, b_cause};

   rv32i_mc_controller #(.WIDTH(32), .MEM_TIMEOUT(4), .HALT_ON_TRAP(0)) dut_a (
      .clk(clk), .rst(rst_a), .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
      .ir_wren(a_ir), .pc_wren(a_pcw), .pc_sel(a_pcs), .regfile_wren(a_rfw), .regfile_sel(a_rfs),
      .alu_a_sel(a_as), .alu_b_sel(a_bs), .mem_req(a_req), .mem_we(a_we), .mem_addr_sel(a_ms),
      .instret(a_ret), .trap(a_trap), .trap_cause(a_cause), .halted(a_halt));

   rv32i_mc_controller #(.WIDTH(32), .MEM_TIMEOUT(16), .HALT_ON_TRAP(1)) dut_b (
      .clk(clk), .rst(rst_b), .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
      .ir_wren(b_ir), .pc_wren(b_pcw), .pc_sel(b_pcs), .regfile_wren(b_rfw), .regfile_sel(b_rfs),
      .alu_a_sel(b_as), .alu_b_sel(b_bs), .mem_req(b_req), .mem_we(b_we), .mem_addr_sel(b_ms),
      .instret(b_ret), .trap(b_trap), .trap_cause(b_cause), .halted(b_halt));

   function automatic bit is_legal(input logic [6:0] op);
      return op inside {OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_BRANCH,
                        OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE};
   endfunction

   function automatic outs_t blank();
      outs_t e;
      e = '0;
      e.trap_cause = cause_exp;
      return e;
   endfunction

   task automatic push(input logic [6:0] op, input logic bt, input logic rdy, input outs_t e, input string tag);
      step_t s;
      s.opcode = op;
      s.branch_taken = bt;
      s.mem_ready = rdy;
      s.exp = e;
      s.tag = tag;
      plan.push_back(s);
   endtask

   task automatic plan_trap(input logic [3:0] cause);
      outs_t e;
      cause_exp = cause;
      e = blank();
      e.trap = 1'b1;
      e.pc_wren = 1'b1;
      e.pc_sel = 2'd3;
      push(7'($urandom), 1'($urandom), 1'($urandom), e, "trap");
   endtask

   // One memory access: wait_n stalled cycles, then completion, or a timeout trap if the stall is too long.
   task automatic plan_access(input bit is_fetch, input logic [6:0] op, input int wait_n, output bit timed_out);
      int    limit;
      outs_t e;
      limit = sel_b ? 16 : 4;
      e = blank();
      e.mem_req = 1'b1;
      if (!is_fetch) begin
         e.mem_addr_sel = 1'b1;
         e.mem_we = (op == OPC_STORE);
      end
      if (wait_n >= limit) begin
         for (int i = 0; i < limit; i++)
            push(is_fetch ? 7'($urandom) : op, 1'($urandom), 1'b0, e, is_fetch ? "fetch_wait" : "mem_wait");
         plan_trap(is_fetch ? 4'd1 : (op == OPC_STORE ? 4'd7 : 4'd5));
         timed_out = 1'b1;
      end else begin
         for (int i = 0; i < wait_n; i++)
            push(is_fetch ? 7'($urandom) : op, 1'($urandom), 1'b0, e, is_fetch ? "fetch_wait" : "mem_wait");
         if (is_fetch) begin
            e.ir_wren = 1'b1;
            e.pc_wren = 1'b1;
         end else begin
            e.instret = (op == OPC_STORE);
         end
         push(is_fetch ? 7'($urandom) : op, 1'($urandom), 1'b1, e, is_fetch ? "fetch_done" : "mem_done");
         timed_out = 1'b0;
      end
   endtask

   // Expected cycle-by-cycle trace of one whole instruction.
   task automatic plan_instr(input logic [6:0] op, input logic taken, input int fw, input int mw);
      bit    to;
      outs_t e;
      plan_access(1'b1, op, fw, to);
      if (to) return;
      push(op, 1'($urandom), 1'($urandom), blank(), "decode");
      if (!is_legal(op)) begin
         plan_trap(4'd2);
         return;
      end
      e = blank();
      case (op)
         OPC_OP:     begin e.regfile_wren = 1; e.instret = 1; end
         OPC_OP_IMM,
         OPC_LUI:    begin e.alu_b_sel = 1; e.regfile_wren = 1; e.instret = 1; end
         OPC_AUIPC:  begin e.alu_a_sel = 1; e.alu_b_sel = 1; e.regfile_wren = 1; e.instret = 1; end
         OPC_BRANCH: begin e.instret = 1; if (taken) begin e.pc_wren = 1; e.pc_sel = 2; end end
         OPC_JAL:    begin e.regfile_wren = 1; e.regfile_sel = 2; e.pc_wren = 1; e.pc_sel = 2; e.instret = 1; end
         OPC_JALR:   begin e.alu_b_sel = 1; e.regfile_wren = 1; e.regfile_sel = 2; e.pc_wren = 1; e.pc_sel = 1; e.instret = 1; end
         default:    e.alu_b_sel = 1;
      endcase
      push(op, (op == OPC_BRANCH) ? taken : 1'($urandom), 1'($urandom), e, "exec");
      if (op == OPC_LOAD || op == OPC_STORE) begin
         plan_access(1'b0, op, mw, to);
         if (to) return;
         if (op == OPC_LOAD) begin
            e = blank();
            e.regfile_wren = 1;
            e.regfile_sel = 1;
            e.instret = 1;
            push(7'($urandom), 1'($urandom), 1'($urandom), e, "wb");
         end
      end
   endtask

   // Replays up to max_steps planned cycles; entered and left at posedge+1.
   task automatic run_plan(input int max_steps);
      step_t s;
      outs_t got;
      int    n;
      n = 0;
      while (plan.size() > 0 && n < max_steps) begin
         s = plan.pop_front();
         opcode = s.opcode;
         branch_taken = s.branch_taken;
         mem_ready = s.mem_ready;
         @(negedge clk);
         got = sel_b ? out_b : out_a;
         checks++;
         if (got !== s.exp) begin
            failures++;
            $display("FAIL %s op=%b got=%h exp=%h", s.tag, s.opcode, got, s.exp);
         end
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic test_reset();
      rst_a = 1'b1;
      rst_b = 1'b1;
      opcode = OPC_STORE;
      mem_ready = 1'b1;
      branch_taken = 1'b1;
      @(negedge clk);
      checks++;
      if (out_a !== '0) begin
         failures++;
         $display("FAIL reset_a got=%h exp=0", out_a);
      end
      checks++;
      if (out_b !== '0) begin
         failures++;
         $display("FAIL reset_b got=%h exp=0", out_b);
      end
      @(posedge clk);
      #1;
      rst_a = 1'b0;
      cause_exp = 4'd0;
   endtask

   task automatic test_alu_ops();
      plan_instr(OPC_OP_IMM, 0, 0, 0);
      plan_instr(OPC_OP, 0, 0, 0);
      plan_instr(OPC_LUI, 0, 1, 0);
      plan_instr(OPC_AUIPC, 0, 0, 0);
      plan_instr(OPC_JAL, 0, 0, 0);
      plan_instr(OPC_JALR, 0, 2, 0);
      run_plan(1000);
   endtask

   task automatic test_load_store();
      plan_instr(OPC_LOAD, 0, 0, 3);
      plan_instr(OPC_STORE, 0, 0, 0);
      plan_instr(OPC_STORE, 0, 1, 2);
      run_plan(1000);
   endtask

   task automatic test_branch();
      plan_instr(OPC_BRANCH, 1, 0, 0);
      plan_instr(OPC_BRANCH, 0, 0, 0);
      run_plan(1000);
   endtask

   task automatic test_illegal();
      plan_instr(7'b0000000, 0, 0, 0);
      plan_instr(7'b1111111, 0, 0, 0);
      plan_instr(OPC_OP_IMM, 0, 0, 0);
      run_plan(1000);
   endtask

   task automatic test_timeout();
      plan_instr(OPC_OP_IMM, 0, 4, 0);
      plan_instr(OPC_OP_IMM, 0, 3, 0);
      plan_instr(OPC_LOAD, 0, 0, 4);
      plan_instr(OPC_LOAD, 0, 0, 3);
      plan_instr(OPC_STORE, 0, 0, 4);
      plan_instr(OPC_STORE, 0, 0, 3);
      run_plan(1000);
   endtask

   task automatic test_reset_mid_store();
      outs_t e;
      plan_instr(7'b0000000, 0, 0, 0);
      run_plan(1000);
      plan_instr(OPC_STORE, 0, 0, 3);
      run_plan(4);
      plan.delete();
      opcode = OPC_STORE;
      mem_ready = 1'b0;
      #2;
      e = blank();
      e.mem_req = 1;
      e.mem_we = 1;
      e.mem_addr_sel = 1;
      checks++;
      if (out_a !== e) begin
         failures++;
         $display("FAIL store_pending got=%h exp=%h", out_a, e);
      end
      rst_a = 1'b1;
      #1;
      checks++;
      if (out_a !== '0) begin
         failures++;
         $display("FAIL reset_mid_store got=%h exp=0", out_a);
      end
      @(posedge clk);
      #1;
      rst_a = 1'b0;
      cause_exp = 4'd0;
      plan_instr(OPC_OP_IMM, 0, 1, 0);
      run_plan(1000);
   endtask

   task automatic test_halt();
      outs_t e;
      rst_a = 1'b1;
      sel_b = 1'b1;
      cause_exp = 4'd0;
      rst_b = 1'b0;
      plan_instr(OPC_OP, 0, 2, 0);
      plan_instr(7'b0000000, 0, 1, 0);
      e = blank();
      e.halted = 1'b1;
      for (int i = 0; i < 6; i++)
         push(legal_ops[$urandom_range(0, 8)], 1'($urandom), 1'($urandom), e, "halt");
      run_plan(1000);
      rst_b = 1'b1;
      #1;
      checks++;
      if (out_b !== '0) begin
         failures++;
         $display("FAIL halt_reset got=%h exp=0", out_b);
      end
      @(posedge clk);
      #1;
      rst_b = 1'b0;
      cause_exp = 4'd0;
      plan_instr(OPC_LUI, 0, 0, 0);
      run_plan(1000);
      rst_b = 1'b1;
      sel_b = 1'b0;
      rst_a = 1'b0;
   endtask

   task automatic test_random();
      logic [6:0] op;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 7) == 0)
            op = 7'($urandom);
         else
            op = legal_ops[$urandom_range(0, 8)];
         plan_instr(op, 1'($urandom), $urandom_range(0, 5), $urandom_range(0, 5));
      end
      run_plan(5000);
   endtask

   initial begin
      test_reset();
      test_alu_ops();
      test_load_store();
      test_branch();
      test_illegal();
      test_timeout();
      test_reset_mid_store();
      test_halt();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
